// File: rtl/svc_axi_mem_pkg.sv
// Shared types and AXI encodings for the svc_axi_mem subordinate.
package svc_axi_mem_pkg;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_t;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_t;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_BURST_INCR  = 2'b01;

endpackage

// File: rtl/svc_axi_mem_if.sv
// AXI4 bus bundle between an initiator (master) and svc_axi_mem (slave).
interface svc_axi_mem_if #(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4
);
  logic                        awvalid, awready;
  logic [AXI_ADDR_WIDTH-1:0]   awaddr;
  logic [AXI_ID_WIDTH-1:0]     awid;
  logic [7:0]                  awlen;
  logic [2:0]                  awsize;
  logic [1:0]                  awburst;

  logic                        wvalid, wready;
  logic [AXI_DATA_WIDTH-1:0]   wdata;
  logic [AXI_DATA_WIDTH/8-1:0] wstrb;
  logic                        wlast;

  logic                        bvalid, bready;
  logic [AXI_ID_WIDTH-1:0]     bid;
  logic [1:0]                  bresp;

  logic                        arvalid, arready;
  logic [AXI_ADDR_WIDTH-1:0]   araddr;
  logic [AXI_ID_WIDTH-1:0]     arid;
  logic [7:0]                  arlen;
  logic [2:0]                  arsize;
  logic [1:0]                  arburst;

  logic                        rvalid, rready;
  logic [AXI_ID_WIDTH-1:0]     rid;
  logic [AXI_DATA_WIDTH-1:0]   rdata;
  logic [1:0]                  rresp;
  logic                        rlast;

  modport master (
    output awvalid, awaddr, awid, awlen, awsize, awburst, input awready,
    output wvalid, wdata, wstrb, wlast, input wready,
    input  bvalid, bid, bresp, output bready,
    output arvalid, araddr, arid, arlen, arsize, arburst, input arready,
    input  rvalid, rid, rdata, rresp, rlast, output rready
  );

  modport slave (
    input  awvalid, awaddr, awid, awlen, awsize, awburst, output awready,
    input  wvalid, wdata, wstrb, wlast, output wready,
    output bvalid, bid, bresp, input bready,
    input  arvalid, araddr, arid, arlen, arsize, arburst, output arready,
    output rvalid, rid, rdata, rresp, rlast, input rready
  );
endinterface

// File: rtl/svc_axi_mem_rd.sv
// Read channel of svc_axi_mem: AR capture, beat sequencing and the R output register.
// SVC_AXI_MEM_ERR_EN enables SLVERR for non-INCR or out-of-range reads.
module svc_axi_mem_rd
  import svc_axi_mem_pkg::*;
#(
  parameter int AXI_DATA_WIDTH = 16,
  parameter int IDX_W          = 8,
  parameter int OFF            = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  svc_axi_mem_if.slave              s_axi,
  output logic [IDX_W-1:0]          rd_idx,
  input  logic [AXI_DATA_WIDTH-1:0] rd_word
);
  r_state_t         r_state, r_next;
  logic [IDX_W-1:0] r_idx, ar_idx;
  logic [7:0]       r_len, r_cnt;
  logic             r_more, r_err, ar_err, ar_hs, r_hs, load;
  logic             unused_ok;

  assign ar_idx = IDX_W'(s_axi.araddr >> OFF);
  assign ar_hs  = s_axi.arvalid && s_axi.arready;
  assign r_hs   = s_axi.rvalid && s_axi.rready;
  assign load   = (r_state == R_DATA) && r_more && (!s_axi.rvalid || s_axi.rready);
  assign rd_idx = (r_state == R_IDLE) ? ar_idx : r_idx;
  assign unused_ok = ^{s_axi.arsize, s_axi.arburst, s_axi.araddr};

`ifdef SVC_AXI_MEM_ERR_EN
  assign ar_err = (s_axi.arburst != AXI_BURST_INCR) || ((s_axi.araddr >> (IDX_W + OFF)) != '0);
`else
  assign ar_err = 1'b0;
`endif

  always_comb begin
    r_next        = r_state;
    s_axi.arready = 1'b0;
    case (r_state)
      R_IDLE: begin
        s_axi.arready = !rst;
        if (s_axi.arvalid && !rst) r_next = R_DATA;
      end
      R_DATA:  if (r_hs && s_axi.rlast) r_next = R_IDLE;
      default: r_next = R_IDLE;
    endcase
  end

  // Beat 0 is fetched on the AR handshake itself so rvalid follows one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= R_IDLE;
      r_idx        <= '0;
      r_len        <= '0;
      r_cnt        <= '0;
      r_more       <= 1'b0;
      r_err        <= 1'b0;
      s_axi.rvalid <= 1'b0;
      s_axi.rlast  <= 1'b0;
      s_axi.rdata  <= '0;
      s_axi.rid    <= '0;
      s_axi.rresp  <= AXI_RESP_OKAY;
    end else begin
      r_state <= r_next;
      if (ar_hs) begin
        r_idx        <= ar_idx + 1'b1;
        r_len        <= s_axi.arlen;
        r_cnt        <= 8'd1;
        r_more       <= (s_axi.arlen != 8'd0);
        r_err        <= ar_err;
        s_axi.rid    <= s_axi.arid;
        s_axi.rresp  <= ar_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
        s_axi.rvalid <= 1'b1;
        s_axi.rlast  <= (s_axi.arlen == 8'd0);
        s_axi.rdata  <= ar_err ? '0 : rd_word;
      end else if (load) begin
        r_idx        <= r_idx + 1'b1;
        r_cnt        <= r_cnt + 1'b1;
        r_more       <= (r_cnt != r_len);
        s_axi.rvalid <= 1'b1;
        s_axi.rlast  <= (r_cnt == r_len);
        s_axi.rdata  <= r_err ? '0 : rd_word;
      end else if (r_hs) begin
        s_axi.rvalid <= 1'b0;
        s_axi.rlast  <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/svc_axi_mem.sv
// AXI4 subordinate backed by a word-addressed array; write FSM and memory live here.
// SVC_AXI_MEM_ERR_EN enables SLVERR for non-INCR or out-of-range bursts.
module svc_axi_mem
  import svc_axi_mem_pkg::*;
#(
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int AXI_DATA_WIDTH = 16,
  parameter int AXI_ID_WIDTH   = 4,
  parameter int MEM_DEPTH      = 256
) (
  input logic          clk,
  input logic          rst,
  svc_axi_mem_if.slave s_axi
);
  localparam int IDX_W = $clog2(MEM_DEPTH);
  localparam int OFF   = $clog2(AXI_DATA_WIDTH / 8);
  localparam int NB    = AXI_DATA_WIDTH / 8;

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_DEPTH];
  logic [AXI_DATA_WIDTH-1:0] rd_word;
  logic [IDX_W-1:0]          w_idx, rd_idx;
  logic [AXI_ID_WIDTH-1:0]   w_id;
  logic [7:0]                w_len, w_cnt;
  logic                      w_err, aw_err, aw_hs, w_hs, unused_ok;
  w_state_t                  w_state, w_next;

  assign aw_hs       = s_axi.awvalid && s_axi.awready;
  assign w_hs        = s_axi.wvalid && s_axi.wready;
  assign s_axi.bid   = w_id;
  assign s_axi.bresp = w_err ? AXI_RESP_SLVERR : AXI_RESP_OKAY;
  assign rd_word     = mem[rd_idx];
  assign unused_ok   = ^{s_axi.awsize, s_axi.awburst, s_axi.awaddr, s_axi.wlast};

`ifdef SVC_AXI_MEM_ERR_EN
  assign aw_err = (s_axi.awburst != AXI_BURST_INCR) || ((s_axi.awaddr >> (IDX_W + OFF)) != '0);
`else
  assign aw_err = 1'b0;
`endif

  always_comb begin
    w_next        = w_state;
    s_axi.awready = 1'b0;
    s_axi.wready  = 1'b0;
    s_axi.bvalid  = 1'b0;
    case (w_state)
      W_IDLE: begin
        s_axi.awready = !rst;
        if (s_axi.awvalid && !rst) w_next = W_DATA;
      end
      W_DATA: begin
        s_axi.wready = 1'b1;
        if (s_axi.wvalid && w_cnt == w_len) w_next = W_RESP;
      end
      W_RESP: begin
        s_axi.bvalid = 1'b1;
        if (s_axi.bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_idx   <= '0;
      w_id    <= '0;
      w_len   <= '0;
      w_cnt   <= '0;
      w_err   <= 1'b0;
    end else begin
      w_state <= w_next;
      if (aw_hs) begin
        w_idx <= IDX_W'(s_axi.awaddr >> OFF);
        w_id  <= s_axi.awid;
        w_len <= s_axi.awlen;
        w_cnt <= '0;
        w_err <= aw_err;
      end else if (w_hs) begin
        w_idx <= w_idx + 1'b1;
        w_cnt <= w_cnt + 1'b1;
      end
    end
  end

  // Contents survive reset; a beat landing in the reset cycle is dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_hs && !w_err) begin
      for (int unsigned b = 0; b < NB; b++) begin
        if (s_axi.wstrb[b]) mem[w_idx][b*8 +: 8] <= s_axi.wdata[b*8 +: 8];
      end
    end
  end

  svc_axi_mem_rd #(
    .AXI_DATA_WIDTH(AXI_DATA_WIDTH),
    .IDX_W         (IDX_W),
    .OFF           (OFF)
  ) u_rd (
    .clk    (clk),
    .rst    (rst),
    .s_axi  (s_axi),
    .rd_idx (rd_idx),
    .rd_word(rd_word)
  );
endmodule

// File: tb/tb_svc_axi_mem.sv
// Directed self-checking bench for svc_axi_mem (16-bit data, 256 words).
module tb_svc_axi_mem;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  logic [15:0] rd_data [16];
  logic        rd_last [16];
  logic [1:0]  rd_resp [16];
  logic [3:0]  rd_id   [16];
  int          rd_cyc  [16];
  int          rd_n, stall_bad;
  logic        first_ok;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  always #5 clk = ~clk;

  svc_axi_mem_if #(.AXI_ADDR_WIDTH(16), .AXI_DATA_WIDTH(16), .AXI_ID_WIDTH(4)) s_axi ();

  svc_axi_mem #(
    .AXI_ADDR_WIDTH(16),
    .AXI_DATA_WIDTH(16),
    .AXI_ID_WIDTH  (4),
    .MEM_DEPTH     (256)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .s_axi(s_axi.slave)
  );

  task automatic do_write(input logic [15:0] addr, input logic [3:0] id, input int len,
                          input logic [1:0] burst, input logic [1:0] strb, input logic [15:0] base);
    int t;
    @(negedge clk);
    s_axi.awvalid = 1'b1; s_axi.awaddr = addr; s_axi.awid = id;
    s_axi.awlen = 8'(len); s_axi.awsize = 3'd1; s_axi.awburst = burst;
    t = 0;
    while (!s_axi.awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL aw_timeout got=0 exp=1"); end
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    for (int i = 0; i <= len; i++) begin
      s_axi.wvalid = 1'b1; s_axi.wdata = 16'(base + 16'(i)); s_axi.wstrb = strb;
      s_axi.wlast = (i == len);
      t = 0;
      while (!s_axi.wready && t < 50) begin @(negedge clk); t++; end
      if (t >= 50) begin checks++; failures++; $display("FAIL w_timeout got=0 exp=1"); end
      @(negedge clk);
    end
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0; s_axi.bready = 1'b1;
    t = 0;
    while (!s_axi.bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL b_timeout got=0 exp=1"); end
    b_resp = s_axi.bresp; b_id = s_axi.bid;
    @(negedge clk);
    s_axi.bready = 1'b0;
  endtask

  task automatic do_read(input logic [15:0] addr, input logic [3:0] id, input int len,
                         input logic [1:0] burst, input logic [3:0] pat);
    int t, cyc;
    logic held, h_last, rr;
    logic [15:0] h_data;
    @(negedge clk);
    s_axi.arvalid = 1'b1; s_axi.araddr = addr; s_axi.arid = id;
    s_axi.arlen = 8'(len); s_axi.arsize = 3'd1; s_axi.arburst = burst;
    t = 0;
    while (!s_axi.arready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL ar_timeout got=0 exp=1"); end
    @(negedge clk);
    s_axi.arvalid = 1'b0;
    rd_n = 0; stall_bad = 0; held = 1'b0; cyc = 0; h_data = '0; h_last = 1'b0;
    first_ok = s_axi.rvalid;
    while (rd_n <= len && cyc < 100) begin
      rr = pat[cyc % 4];
      s_axi.rready = rr;
      if (held && (!s_axi.rvalid || s_axi.rdata !== h_data || s_axi.rlast !== h_last)) stall_bad++;
      held = 1'b0;
      if (s_axi.rvalid && rr) begin
        rd_data[rd_n] = s_axi.rdata; rd_last[rd_n] = s_axi.rlast;
        rd_resp[rd_n] = s_axi.rresp; rd_id[rd_n] = s_axi.rid; rd_cyc[rd_n] = cyc;
        rd_n++;
      end else if (s_axi.rvalid) begin
        held = 1'b1; h_data = s_axi.rdata; h_last = s_axi.rlast;
      end
      @(negedge clk);
      cyc++;
    end
    s_axi.rready = 1'b0;
    if (cyc >= 100) begin checks++; failures++; $display("FAIL r_timeout got=%0d exp=%0d", rd_n, len + 1); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({s_axi.awready, s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast,
         s_axi.bresp, s_axi.rresp, s_axi.bid, s_axi.rid, s_axi.rdata} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got=%b%b%b%b%b%b rdata=%h exp=000000 rdata=0000", s_axi.awready,
               s_axi.wready, s_axi.bvalid, s_axi.arready, s_axi.rvalid, s_axi.rlast, s_axi.rdata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({s_axi.awready, s_axi.arready} !== 2'b11) begin
      failures++; $display("FAIL ready_after_reset got=%b exp=11", {s_axi.awready, s_axi.arready});
    end
  endtask

  task automatic test_single();
    do_write(16'h0010, 4'h3, 0, 2'b01, 2'b11, 16'hA5A5);
    checks++;
    if ({b_resp, b_id} !== {2'b00, 4'h3}) begin
      failures++; $display("FAIL single_b got=%b/%h exp=00/3", b_resp, b_id);
    end
    do_read(16'h0010, 4'h5, 0, 2'b01, 4'b1111);
    checks++;
    if ({rd_data[0], rd_last[0], rd_resp[0], rd_id[0], first_ok} !== {16'hA5A5, 1'b1, 2'b00, 4'h5, 1'b1}) begin
      failures++;
      $display("FAIL single_r got=%h/%b/%b/%h/%b exp=a5a5/1/00/5/1", rd_data[0], rd_last[0],
               rd_resp[0], rd_id[0], first_ok);
    end
  endtask

  task automatic test_burst();
    do_write(16'h0020, 4'h1, 7, 2'b01, 2'b11, 16'h1000);
    do_read(16'h0020, 4'h2, 7, 2'b01, 4'b1111);
    checks++;
    if (rd_n !== 8) begin failures++; $display("FAIL burst_count got=%0d exp=8", rd_n); end
    for (int i = 0; i < 8; i++) begin
      checks++;
      if ({rd_data[i], rd_last[i], rd_cyc[i]} !== {16'(16'h1000 + 16'(i)), (i == 7), i}) begin
        failures++;
        $display("FAIL burst_beat%0d got=%h/%b/c%0d exp=%h/%b/c%0d", i, rd_data[i], rd_last[i],
                 rd_cyc[i], 16'(16'h1000 + 16'(i)), (i == 7), i);
      end
    end
  endtask

  task automatic test_strobe();
    do_write(16'h0040, 4'h0, 0, 2'b01, 2'b11, 16'hFFFF);
    do_write(16'h0040, 4'h0, 0, 2'b01, 2'b01, 16'h1234);
    do_read(16'h0040, 4'h0, 0, 2'b01, 4'b1111);
    checks++;
    if (rd_data[0] !== 16'hFF34) begin failures++; $display("FAIL strobe got=%h exp=ff34", rd_data[0]); end
  endtask

  task automatic test_backpressure();
    do_write(16'h0060, 4'h0, 3, 2'b01, 2'b11, 16'hB000);
    do_read(16'h0060, 4'h9, 3, 2'b01, 4'b1001);
    checks++;
    if (stall_bad !== 0) begin failures++; $display("FAIL bp_stable got=%0d exp=0", stall_bad); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({rd_data[i], rd_id[i], rd_last[i]} !== {16'(16'hB000 + 16'(i)), 4'h9, (i == 3)}) begin
        failures++;
        $display("FAIL bp_beat%0d got=%h/%h/%b exp=%h/9/%b", i, rd_data[i], rd_id[i], rd_last[i],
                 16'(16'hB000 + 16'(i)), (i == 3));
      end
    end
  endtask

  task automatic test_wrap();
    do_write(16'h01FC, 4'h1, 3, 2'b01, 2'b11, 16'hC000);
    do_read(16'h0000, 4'h1, 1, 2'b01, 4'b1111);
    checks++;
    if ({rd_data[0], rd_data[1]} !== {16'hC002, 16'hC003}) begin
      failures++; $display("FAIL wrap_low got=%h,%h exp=c002,c003", rd_data[0], rd_data[1]);
    end
    do_read(16'h01FC, 4'h1, 3, 2'b01, 4'b1111);
    checks++;
    if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== 64'hC000_C001_C002_C003) begin
      failures++;
      $display("FAIL wrap_read got=%h,%h,%h,%h exp=c000,c001,c002,c003", rd_data[0], rd_data[1],
               rd_data[2], rd_data[3]);
    end
  endtask

  task automatic test_concurrent();
    int t;
    do_write(16'h0080, 4'h0, 0, 2'b01, 2'b11, 16'h1111);
    @(negedge clk);
    s_axi.awvalid = 1'b1; s_axi.awaddr = 16'h0080; s_axi.awid = 4'h2;
    s_axi.awlen = 8'd0; s_axi.awburst = 2'b01;
    t = 0;
    while (!s_axi.awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL cc_aw_timeout got=0 exp=1"); end
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    s_axi.wvalid = 1'b1; s_axi.wdata = 16'h2222; s_axi.wstrb = 2'b11; s_axi.wlast = 1'b1;
    s_axi.arvalid = 1'b1; s_axi.araddr = 16'h0080; s_axi.arid = 4'h6;
    s_axi.arlen = 8'd0; s_axi.arburst = 2'b01;
    checks++;
    if ({s_axi.wready, s_axi.arready} !== 2'b11) begin
      failures++; $display("FAIL cc_aligned got=%b exp=11", {s_axi.wready, s_axi.arready});
    end
    @(negedge clk);
    s_axi.wvalid = 1'b0; s_axi.wlast = 1'b0; s_axi.arvalid = 1'b0;
    checks++;
    if ({s_axi.rvalid, s_axi.rdata} !== {1'b1, 16'h1111}) begin
      failures++; $display("FAIL cc_old_data got=%b/%h exp=1/1111", s_axi.rvalid, s_axi.rdata);
    end
    s_axi.rready = 1'b1; s_axi.bready = 1'b1;
    t = 0;
    while (!s_axi.bvalid && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL cc_b_timeout got=0 exp=1"); end
    @(negedge clk);
    s_axi.rready = 1'b0; s_axi.bready = 1'b0;
    do_read(16'h0080, 4'h0, 0, 2'b01, 4'b1111);
    checks++;
    if (rd_data[0] !== 16'h2222) begin failures++; $display("FAIL cc_new_data got=%h exp=2222", rd_data[0]); end
  endtask

  task automatic test_reset_mid();
    int t;
    do_write(16'h00A0, 4'h0, 3, 2'b01, 2'b11, 16'h0000);
    @(negedge clk);
    s_axi.awvalid = 1'b1; s_axi.awaddr = 16'h00A0; s_axi.awlen = 8'd3; s_axi.awburst = 2'b01;
    t = 0;
    while (!s_axi.awready && t < 50) begin @(negedge clk); t++; end
    if (t >= 50) begin checks++; failures++; $display("FAIL rm_aw_timeout got=0 exp=1"); end
    @(negedge clk);
    s_axi.awvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      s_axi.wvalid = 1'b1; s_axi.wdata = 16'(16'hE000 + 16'(i)); s_axi.wstrb = 2'b11;
      @(negedge clk);
    end
    s_axi.wvalid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({s_axi.wready, s_axi.bvalid} !== 2'b00) begin
      failures++; $display("FAIL rm_abort got=%b exp=00", {s_axi.wready, s_axi.bvalid});
    end
    rst = 1'b0;
    do_read(16'h00A0, 4'h0, 3, 2'b01, 4'b1111);
    checks++;
    if ({rd_data[0], rd_data[1], rd_data[2], rd_data[3]} !== 64'hE000_E001_0002_0003) begin
      failures++;
      $display("FAIL rm_partial got=%h,%h,%h,%h exp=e000,e001,0002,0003", rd_data[0], rd_data[1],
               rd_data[2], rd_data[3]);
    end
  endtask

`ifdef SVC_AXI_MEM_ERR_EN
  task automatic test_err();
    do_write(16'h0010, 4'h1, 0, 2'b00, 2'b11, 16'hDEAD);
    checks++;
    if (b_resp !== 2'b10) begin failures++; $display("FAIL err_w_fixed got=%b exp=10", b_resp); end
    do_write(16'h0210, 4'h1, 0, 2'b01, 2'b11, 16'hBEEF);
    checks++;
    if (b_resp !== 2'b10) begin failures++; $display("FAIL err_w_range got=%b exp=10", b_resp); end
    do_read(16'h0010, 4'h1, 0, 2'b01, 4'b1111);
    checks++;
    if ({rd_resp[0], rd_data[0]} !== {2'b00, 16'hA5A5}) begin
      failures++; $display("FAIL err_mem_kept got=%b/%h exp=00/a5a5", rd_resp[0], rd_data[0]);
    end
    do_read(16'h0210, 4'h1, 0, 2'b01, 4'b1111);
    checks++;
    if ({rd_resp[0], rd_data[0]} !== {2'b10, 16'h0000}) begin
      failures++; $display("FAIL err_r_range got=%b/%h exp=10/0000", rd_resp[0], rd_data[0]);
    end
    do_read(16'h0010, 4'h1, 0, 2'b00, 4'b1111);
    checks++;
    if ({rd_resp[0], rd_data[0]} !== {2'b10, 16'h0000}) begin
      failures++; $display("FAIL err_r_fixed got=%b/%h exp=10/0000", rd_resp[0], rd_data[0]);
    end
  endtask
`endif

  initial begin
    s_axi.awvalid = 1'b0; s_axi.awaddr = '0; s_axi.awid = '0; s_axi.awlen = '0;
    s_axi.awsize = 3'd1; s_axi.awburst = 2'b01;
    s_axi.wvalid = 1'b0; s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wlast = 1'b0;
    s_axi.bready = 1'b0;
    s_axi.arvalid = 1'b0; s_axi.araddr = '0; s_axi.arid = '0; s_axi.arlen = '0;
    s_axi.arsize = 3'd1; s_axi.arburst = 2'b01;
    s_axi.rready = 1'b0;

    test_reset();
    test_single();
    test_burst();
    test_strobe();
    test_backpressure();
    test_wrap();
    test_concurrent();
    test_reset_mid();
`ifdef SVC_AXI_MEM_ERR_EN
    test_err();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
